// File: rtl/dmem_access_ctrl_if.sv
// Memory-stage access bus between the pipeline (master) and the data-memory
// access controller (slave): request operands in, read result and status out.
interface dmem_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_done;
    logic        mem_error;
    logic        mem_busy;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_done, mem_error, mem_busy
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_done, mem_error, mem_busy
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Serialises 64-bit memory-stage accesses into eight little-endian byte beats on a
// byte-wide single-port RAM, shared with a loader port that wins whenever the FSM is idle.
module dmem_access_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    dmem_access_ctrl_if.slave mem,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_wdata,
    output logic              ld_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    // Highest base address whose eight bytes still fit in the RAM.
    localparam logic [63:0] LAST_OK = 64'(MEM_BYTES) - 64'd8;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        DRAIN,
        DONE
    } state_t;

    state_t            state;
    logic [2:0]        beat;
    logic [ADDR_W-1:0] base;
    logic [63:0]       wdata_q;
    logic [55:0]       rd_buf;
    logic [63:0]       rdata_q;
    logic              err;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            beat    <= 3'd0;
            base    <= '0;
            wdata_q <= 64'd0;
            rd_buf  <= 56'd0;
            rdata_q <= 64'd0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!ld_req && mem.mem_req) begin
                        if (mem.mem_addr > LAST_OK) begin
                            err   <= 1'b1;
                            state <= DONE;
                        end else begin
                            base    <= mem.mem_addr[ADDR_W-1:0];
                            wdata_q <= mem.mem_wdata;
                            beat    <= 3'd0;
                            state   <= mem.mem_we ? WR : RD;
                        end
                    end
                end
                WR: begin
                    // Write data shifts down so the current byte is always at the bottom.
                    wdata_q <= {8'd0, wdata_q[63:8]};
                    beat    <= beat + 3'd1;
                    if (beat == 3'd7) begin
                        state <= DONE;
                    end
                end
                RD: begin
                    // RAM data lags the address by a cycle; bytes 0..6 shift in from the top.
                    if (beat != 3'd0) begin
                        rd_buf <= {ram_rdata, rd_buf[55:8]};
                    end
                    beat <= beat + 3'd1;
                    if (beat == 3'd7) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    rdata_q <= {ram_rdata, rd_buf};
                    state   <= DONE;
                end
                DONE: begin
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // RAM port mux: loader only while idle, otherwise the active beat.
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = 8'd0;
        ld_ack    = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (ld_req) begin
                        ram_addr  = ld_addr;
                        ram_wdata = ld_wdata;
                        ram_we    = 1'b1;
                        ld_ack    = 1'b1;
                    end
                end
                WR: begin
                    ram_addr  = base + ADDR_W'(beat);
                    ram_wdata = wdata_q[7:0];
                    ram_we    = 1'b1;
                end
                RD: begin
                    ram_addr = base + ADDR_W'(beat);
                end
                default: begin
                    ram_addr = '0;
                end
            endcase
        end
    end

    assign mem.mem_rdata = rdata_q;
    assign mem.mem_done  = (state == DONE);
    assign mem.mem_error = (state == DONE) && err;
    assign mem.mem_busy  = (state != IDLE);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: a byte-array reference model predicts each
// access result, and a negedge monitor checks every mem_done against the queue.
module tb_dmem_access_ctrl;

    localparam int ADDR_W    = 10;
    localparam int MEM_BYTES = 1024;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          done_cyc;
        int          we_cnt;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [7:0]        ld_wdata;
    logic              ld_ack;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    logic [7:0]  env_ram [MEM_BYTES];
    logic [7:0]  ref_ram [MEM_BYTES];
    logic [63:0] last_rdata;
    exp_t        sb [$];
    int          cyc = 0;
    int          we_seen = 0;
    int          total = 0;
    int          bad = 0;

    dmem_access_ctrl_if mem_if ();

    dmem_access_ctrl #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem       (mem_if),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_ack    (ld_ack),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte-wide RAM with registered read data.
    always @(posedge clk) begin
        if (ram_we) env_ram[ram_addr] <= ram_wdata;
        ram_rdata <= env_ram[ram_addr];
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: counts non-loader RAM writes and scores every completion.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            we_seen = 0;
        end else begin
            if (ram_we && !ld_ack) we_seen++;
            if (mem_if.mem_done) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("mem_rdata", mem_if.mem_rdata, e.rdata);
                    checkOutput("mem_error", 64'(mem_if.mem_error), 64'(e.err));
                    checkOutput("latency", 64'(cyc), 64'(e.done_cyc));
                    checkOutput("ram_we_beats", 64'(we_seen), 64'(e.we_cnt));
                end
                we_seen = 0;
            end
        end
    end

    task automatic waitDone();
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (mem_if.mem_done) seen = 1;
        end
        if (!seen) checkOutput("done_timeout", 64'd0, 64'd1);
    endtask

    // Issues one access (optionally colliding with a loader write); called just after a posedge.
    task automatic applyStimulus(input logic we, input logic [63:0] addr, input logic [63:0] data,
                                 input bit with_ld, input logic [ADDR_W-1:0] la, input logic [7:0] ldd);
        exp_t e;
        int   lat;
        if (with_ld) ref_ram[la] = ldd;
        e.rdata  = last_rdata;
        e.err    = 1'b0;
        e.we_cnt = 0;
        if (addr > 64'(MEM_BYTES - 8)) begin
            lat   = 1;
            e.err = 1'b1;
        end else if (we) begin
            lat      = 9;
            e.we_cnt = 8;
            for (int i = 0; i < 8; i++) ref_ram[int'(addr[ADDR_W-1:0]) + i] = data[8*i +: 8];
        end else begin
            lat = 10;
            for (int i = 0; i < 8; i++) e.rdata[8*i +: 8] = ref_ram[int'(addr[ADDR_W-1:0]) + i];
            last_rdata = e.rdata;
        end
        e.done_cyc = cyc + lat + (with_ld ? 1 : 0);
        sb.push_back(e);
        mem_if.mem_req   = 1'b1;
        mem_if.mem_we    = we;
        mem_if.mem_addr  = addr;
        mem_if.mem_wdata = data;
        if (with_ld) begin
            ld_req   = 1'b1;
            ld_addr  = la;
            ld_wdata = ldd;
            @(negedge clk);
            checkOutput("ld_ack", 64'(ld_ack), 64'd1);
            checkOutput("ld_ram_addr", 64'(ram_addr), 64'(la));
            @(posedge clk) #2;
            ld_req = 1'b0;
            checkOutput("ld_ram_byte", 64'(env_ram[la]), 64'(ldd));
            checkOutput("ld_busy", 64'(mem_if.mem_busy), 64'd0);
        end
        waitDone();
        @(posedge clk) #2;
        mem_if.mem_req = 1'b0;
        mem_if.mem_we  = 1'b0;
    endtask

    task automatic loaderWrite(input logic [ADDR_W-1:0] la, input logic [7:0] ldd);
        ref_ram[la] = ldd;
        ld_req   = 1'b1;
        ld_addr  = la;
        ld_wdata = ldd;
        @(negedge clk);
        checkOutput("ld_ack_solo", 64'(ld_ack), 64'd1);
        @(posedge clk) #2;
        ld_req = 1'b0;
    endtask

    initial begin
        logic [63:0] a;
        int          r;
        for (int i = 0; i < MEM_BYTES; i++) begin
            env_ram[i] = 8'd0;
            ref_ram[i] = 8'd0;
        end
        last_rdata       = 64'd0;
        reset            = 1'b1;
        ld_req           = 1'b0;
        ld_addr          = '0;
        ld_wdata         = 8'd0;
        mem_if.mem_req   = 1'b0;
        mem_if.mem_we    = 1'b0;
        mem_if.mem_addr  = 64'd0;
        mem_if.mem_wdata = 64'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 64'(mem_if.mem_busy), 64'd0);
        checkOutput("rst_done", 64'(mem_if.mem_done), 64'd0);
        checkOutput("rst_error", 64'(mem_if.mem_error), 64'd0);
        checkOutput("rst_rdata", mem_if.mem_rdata, 64'd0);
        checkOutput("rst_ram_we", 64'(ram_we), 64'd0);
        checkOutput("rst_ram_addr", 64'(ram_addr), 64'd0);
        checkOutput("rst_ram_wdata", 64'(ram_wdata), 64'd0);
        checkOutput("rst_ld_ack", 64'(ld_ack), 64'd0);
        @(posedge clk) #2;
        reset = 1'b0;

        $display("[TB] directed accesses");
        applyStimulus(1'b1, 64'd16, 64'h1122334455667788, 0, '0, 8'd0);
        for (int i = 0; i < 8; i++) checkOutput("wr_byte", 64'(env_ram[16+i]), 64'(ref_ram[16+i]));
        applyStimulus(1'b0, 64'd16, 64'd0, 0, '0, 8'd0);
        applyStimulus(1'b0, 64'd1016, 64'd0, 0, '0, 8'd0);
        applyStimulus(1'b0, 64'd1017, 64'd0, 0, '0, 8'd0);
        applyStimulus(1'b1, 64'hFFFFFFFFFFFFFFFC, 64'hDEADBEEFCAFEF00D, 0, '0, 8'd0);
        applyStimulus(1'b0, 64'd0, 64'd0, 1, 10'd5, 8'hAB);

        // Reset lands during beat 4 of a read; the transfer must vanish without a completion.
        mem_if.mem_req  = 1'b1;
        mem_if.mem_we   = 1'b0;
        mem_if.mem_addr = 64'd16;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk) #2;
        reset          = 1'b0;
        mem_if.mem_req = 1'b0;
        last_rdata     = 64'd0;
        @(negedge clk);
        checkOutput("abort_busy", 64'(mem_if.mem_busy), 64'd0);
        checkOutput("abort_done", 64'(mem_if.mem_done), 64'd0);
        @(posedge clk) #2;
        applyStimulus(1'b0, 64'd16, 64'd0, 0, '0, 8'd0);

        $display("[TB] random accesses");
        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 9));
            a = 64'($urandom_range(0, MEM_BYTES - 8));
            if (r <= 1) begin
                loaderWrite(ADDR_W'($urandom_range(0, MEM_BYTES - 1)), 8'($urandom));
            end else if (r <= 4) begin
                applyStimulus(1'b1, a, {$urandom, $urandom}, ($urandom_range(0, 3) == 0),
                              ADDR_W'($urandom), 8'($urandom));
            end else if (r <= 7) begin
                applyStimulus(1'b0, a, 64'd0, ($urandom_range(0, 3) == 0),
                              ADDR_W'($urandom), 8'($urandom));
            end else if (r == 8) begin
                applyStimulus(1'($urandom), 64'($urandom_range(MEM_BYTES - 7, MEM_BYTES + 40)),
                              {$urandom, $urandom}, 0, '0, 8'd0);
            end else begin
                applyStimulus(1'($urandom), {$urandom, $urandom} | 64'h0000_0001_0000_0000,
                              {$urandom, $urandom}, 0, '0, 8'd0);
            end
        end

        repeat (4) @(posedge clk);
        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        for (int i = 0; i < MEM_BYTES; i++) begin
            if (env_ram[i] !== ref_ram[i]) checkOutput("final_ram", 64'(env_ram[i]), 64'(ref_ram[i]));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
